leaf_max_arbiter: RTL

- Arbitrates the dual-port t_max_leaf BRAM (one entry per rayID) between one read requester (leaf-end lookup from the list pipeline) and two write requesters (trav0/trav1 new-leaf writes).
- Read always owns port A. Writers share port B, and port A when it is idle, under round-robin.
- Tracks read latency and returns an aligned response.
- Sits between list-unit control and the BRAM macro; the BRAM stays outside this block.

---
 rtl/leaf_max_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/leaf_max_arbiter.sv
// Arbiter for the dual-port t_max_leaf BRAM: one never-stalled reader on port A and two
// round-robin writers on port B (and port A when no read is pending). Optional read-after-write
// forwarding is enabled with `define LEAF_MAX_ARB_BYPASS_EN.
//
// Handshake: a writer whose *_valid is high with *_stall low is accepted in that cycle; with
// *_stall high it must hold valid/addr/data unchanged into the next cycle. Reads have no
// backpressure and complete exactly RD_LAT cycles later on rd_resp_valid/rd_resp_data.
module leaf_max_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_stall,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_stall,
    output logic [ADDR_W-1:0] bram_addr_a,
    output logic [DATA_W-1:0] bram_wdata_a,
    output logic              bram_wren_a,
    input  logic [DATA_W-1:0] bram_q_a,
    output logic [ADDR_W-1:0] bram_addr_b,
    output logic [DATA_W-1:0] bram_wdata_b,
    output logic              bram_wren_b,
    output logic [CNT_W-1:0]  contend_cnt
);

    // Round-robin pointer: 0 prefers wr0, 1 prefers wr1.
    logic             rrp_q, rrp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic contend;
    logic a_use_wr0;
    logic b_use_wr0;
    logic b_use_wr1;

    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] raddr_q, raddr_d;

    // Contention exists when port A is taken by a read, or both writers target one row.
    always_comb begin
        contend   = wr0_valid & wr1_valid & (rd_valid | (wr0_addr == wr1_addr));
        wr0_stall = contend & rrp_q;
        wr1_stall = contend & ~rrp_q;
        a_use_wr0 = ~rd_valid & ~contend & wr0_valid;
        b_use_wr0 = (rd_valid | contend) & wr0_valid & ~wr0_stall;
        b_use_wr1 = wr1_valid & ~wr1_stall;
    end

    always_comb begin
        bram_addr_a  = '0;
        bram_wdata_a = '0;
        bram_wren_a  = 1'b0;
        if (rd_valid) begin
            bram_addr_a = rd_addr;
        end else if (a_use_wr0) begin
            bram_addr_a  = wr0_addr;
            bram_wdata_a = wr0_data;
            bram_wren_a  = rst;
        end
    end

    always_comb begin
        bram_addr_b  = '0;
        bram_wdata_b = '0;
        bram_wren_b  = 1'b0;
        if (b_use_wr0) begin
            bram_addr_b  = wr0_addr;
            bram_wdata_b = wr0_data;
            bram_wren_b  = rst;
        end else if (b_use_wr1) begin
            bram_addr_b  = wr1_addr;
            bram_wdata_b = wr1_data;
            bram_wren_b  = rst;
        end
    end

    always_comb begin
        rrp_d = rrp_q ^ contend;
        cnt_d = cnt_q;
        if (contend && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        vld_d      = '0;
        raddr_d    = '0;
        vld_d[0]   = rd_valid;
        raddr_d[0] = rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            raddr_d[i] = raddr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrp_q   <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= '0;
            raddr_q <= '0;
        end else begin
            rrp_q   <= rrp_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            raddr_q <= raddr_d;
        end
    end

    assign contend_cnt   = cnt_q;
    assign rd_resp_valid = vld_q[RD_LAT-1];

`ifdef LEAF_MAX_ARB_BYPASS_EN
    logic [RD_LAT-1:0]             fwd_q, fwd_d;
    logic [RD_LAT-1:0][DATA_W-1:0] fdata_q, fdata_d;

    // Every in-flight read snoops this cycle's writes; port B is applied last so it wins.
    always_comb begin
        fwd_d   = '0;
        fdata_d = '0;
        for (int i = 1; i < RD_LAT; i++) begin
            fwd_d[i]   = fwd_q[i-1];
            fdata_d[i] = fdata_q[i-1];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            if (bram_wren_a && (bram_addr_a == raddr_d[i])) begin
                fwd_d[i]   = 1'b1;
                fdata_d[i] = bram_wdata_a;
            end
            if (bram_wren_b && (bram_addr_b == raddr_d[i])) begin
                fwd_d[i]   = 1'b1;
                fdata_d[i] = bram_wdata_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_q   <= '0;
            fdata_q <= '0;
        end else begin
            fwd_q   <= fwd_d;
            fdata_q <= fdata_d;
        end
    end

    always_comb begin
        rd_resp_data = '0;
        if (vld_q[RD_LAT-1]) begin
            rd_resp_data = fwd_q[RD_LAT-1] ? fdata_q[RD_LAT-1] : bram_q_a;
        end
    end
`else
    always_comb begin
        rd_resp_data = '0;
        if (vld_q[RD_LAT-1]) begin
            rd_resp_data = bram_q_a;
        end
    end
`endif

endmodule
